// File: rtl/fcvt_s_int.sv
// fcvt_s_int: 3-stage pipelined integer-to-IEEE-754-single converter (fcvt.s.w/wu/l/lu)
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   in_valid/in_ready      operand handshake; in_ready = pipeline advance
//   rs1, is_signed, rm     integer operand, signedness, rounding mode (reserved -> RNE)
//   out_valid/out_ready    result handshake
//   out, fflags            single-precision result and {NV,DZ,OF,UF,NX}
module fcvt_s_int #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] rs1,
    input  logic            is_signed,
    input  logic [2:0]      rm,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out,
    output logic [4:0]      fflags
);
    localparam int LATENCY = 3;
    localparam int PW = $clog2(XLEN);
    localparam int NW = XLEN - 1;

    logic [LATENCY-1:0] vld;
    logic               adv;
    logic               sign_in;
    logic [XLEN-1:0]    mag_in;
    logic               s1_sign, s1_zero;
    logic [2:0]         s1_rm;
    logic [XLEN-1:0]    s1_mag;
    logic [PW-1:0]      lz_p;
    logic [NW-1:0]      lz_norm;
    logic               s2_sign, s2_zero;
    logic [2:0]         s2_rm;
    logic [PW-1:0]      s2_p;
    logic [NW-1:0]      s2_norm;
    logic               g, st, lsb, inc, carry, nx;
    logic [22:0]        frac;
    logic [7:0]         exp_r;
    logic [31:0]        res;

    assign adv       = out_ready | ~vld[LATENCY-1];
    assign in_ready  = adv;
    assign out_valid = vld[LATENCY-1];
    assign sign_in   = is_signed & rs1[XLEN-1];
    assign mag_in    = sign_in ? -rs1 : rs1;

    // Leading-one search; the normalised magnitude drops the leading one, which is implicit
    always_comb begin
        lz_p = '0;
        for (int i = 0; i < XLEN; i++) lz_p = s1_mag[i] ? PW'(i) : lz_p;
        lz_norm = NW'(s1_mag << (PW'(NW) - lz_p));
    end

    always_comb begin
        g     = s2_norm[XLEN-25];
        st    = |s2_norm[XLEN-26:0];
        lsb   = s2_norm[XLEN-24];
        inc   = s2_rm == 3'd1 ? 1'b0 :
                s2_rm == 3'd2 ? s2_sign & (g | st) :
                s2_rm == 3'd3 ? ~s2_sign & (g | st) :
                s2_rm == 3'd4 ? g : g & (st | lsb);
        // A carry out of the fraction means 1.111..1 rounded up to 2.0: frac wraps to 0, exponent bumps
        {carry, frac} = {1'b0, s2_norm[NW-1 -: 23]} + 24'(inc);
        exp_r = 8'd127 + 8'(s2_p) + {7'd0, carry};
        res   = s2_zero ? 32'd0 : {s2_sign, exp_r, frac};
        nx    = ~s2_zero & (g | st);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld     <= '0;
            s1_sign <= 1'b0;
            s1_zero <= 1'b0;
            s1_rm   <= '0;
            s1_mag  <= '0;
            s2_sign <= 1'b0;
            s2_zero <= 1'b0;
            s2_rm   <= '0;
            s2_p    <= '0;
            s2_norm <= '0;
            out     <= '0;
            fflags  <= '0;
        end else if (adv) begin
            vld     <= {vld[LATENCY-2:0], in_valid};
            s1_sign <= sign_in;
            s1_zero <= ~|rs1;
            s1_rm   <= rm;
            s1_mag  <= mag_in;
            s2_sign <= s1_sign;
            s2_zero <= s1_zero;
            s2_rm   <= s1_rm;
            s2_p    <= lz_p;
            s2_norm <= lz_norm;
            out     <= res;
            fflags  <= {4'b0, nx};
        end
    end
endmodule

// File: doc/fcvt_s_int.md
FCVT_S_INT -- requirements
Module: fcvt_s_int

Interface
REQ-001 SHALL have parameter XLEN, default 32, integer source width; legal values 32 and 64.
REQ-002 SHALL have parameter LATENCY, fixed at 3, the pipeline depth from accept to result (not overridable).
REQ-003 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-004 SHALL have port resetn, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1, source operand present.
REQ-006 SHALL have port in_ready, output, 1, block can accept this cycle.
REQ-007 SHALL have port rs1, input, XLEN, integer operand.
REQ-008 SHALL have port is_signed, input, 1; 1 = two's-complement (fcvt.s.w/l), 0 = unsigned (fcvt.s.wu/lu).
REQ-009 SHALL have port rm, input, 3, rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM.
REQ-010 SHALL have port out_valid, output, 1, result present.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-012 SHALL have port out, output, 32, IEEE-754 single result.
REQ-013 SHALL have port fflags, output, 5, {NV,DZ,OF,UF,NX}, aligned with out.

Function
REQ-014 Transfer in SHALL occur when in_valid && in_ready; transfer out when out_valid && out_ready.
REQ-015 Pipeline SHALL advance when out_ready || !out_valid; in_ready SHALL equal that advance condition (combinational, no bubble on continuous flow).
REQ-016 Throughput SHALL be one conversion per cycle; with out_ready held 1, result SHALL appear with out_valid=1 exactly 3 cycles after acceptance.
REQ-017 When stalled, every stage register incl. out/fflags SHALL hold; no item dropped, duplicated or reordered.
REQ-018 Stage 1 SHALL register sign = is_signed & rs1[XLEN-1], magnitude = sign ? -rs1 : rs1 (XLEN-bit unsigned, so INT_MIN gives 2^(XLEN-1)), zero flag, rm.
REQ-019 Stage 2 SHALL register leading-one position p (0..XLEN-1) and the magnitude normalised so the leading one is at bit XLEN-1.
REQ-020 Stage 3 SHALL form 24-bit significand, guard bit (next lower bit) and sticky (OR of all lower bits), round, and pack out = {sign, 127+p, frac[22:0]}.
REQ-021 Rounding increment: RNE guard&(sticky|lsb); RTZ 0; RDN sign&(guard|sticky); RUP !sign&(guard|sticky); RMM guard.
REQ-022 Significand carry-out on rounding SHALL give frac=0 and exponent 127+p+1.
REQ-023 Zero operand SHALL give out=0x00000000 (+0, both modes, any rm), fflags=0.
REQ-024 NX SHALL be guard|sticky; NV, DZ, OF, UF SHALL always be 0 (no overflow is possible for XLEN<=64).
REQ-025 Reserved rm (101, 110, 111) SHALL be treated as RNE; dynamic rm is resolved upstream.
REQ-026 When p<=23 the conversion SHALL be exact (guard=sticky=0).

Reset
REQ-027 While resetn=0: out_valid=0, out=0, fflags=0, all stage valids cleared, in_ready=1 (out_valid=0 makes the pipeline free).
REQ-028 Assertion of resetn mid-operation SHALL discard all in-flight items immediately and asynchronously; no stale result after release.
REQ-029 First acceptance SHALL be possible on the first rising edge with resetn=1.

Verification
REQ-030 XLEN=32, unsigned, 0xFFFFFFFF: RNE -> 0x4F800000 NX=1; RTZ -> 0x4F7FFFFF NX=1.
REQ-031 XLEN=32, signed: 0x80000000 -> 0xCF000000 NX=0; 0xFFFFFFFF -> 0xBF800000 NX=0; 0 -> 0x00000000; unsigned 5 -> 0x40A00000.
REQ-032 Tie: 0x01000001 RNE -> 0x4B800000 NX=1; RUP -> 0x4B800001; RMM -> 0x4B800001; signed 0xFEFFFFFF (-16777217) RDN -> 0xCB800001.
REQ-033 XLEN=64: unsigned 0xFFFFFFFFFFFFFFFF RNE -> 0x5F800000 NX=1; signed 0x8000000000000000 -> 0xDF000000 NX=0.
REQ-034 Back-pressure: 6 back-to-back inputs, out_ready=0 for 5 cycles mid-stream -> in_ready drops while full, all 6 results emerge in order, none lost or duplicated; 3-cycle latency when unstalled.
REQ-035 Reset mid-flight: 3 items in pipe, resetn pulsed low -> out_valid=0 immediately, no result from those items after release, next input converts normally.
